flash_read_cache: RTL and testbench

//  Small direct-mapped read cache between the CPU bus and mem_ctrl. Sits downstream
//  of the CPU's register-space filter and upstream of mem_ctrl (bus_read/bus_write already

---
 rtl/flash_read_cache_pkg.sv | 11 +
 rtl/flash_read_cache_array.sv | 54 +++++
 rtl/flash_read_cache.sv | 146 ++++++++++++++
 tb/tb_flash_read_cache.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/flash_read_cache_pkg.sv
// Shared definitions for the flash read cache: bus widths, flash-window select bit, FSM states.
package flash_read_cache_pkg;
  localparam int unsigned ADDR_W        = 16;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned FLASH_SEL_BIT = 15;  // addr[15]=0 selects the cacheable flash window

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;
endpackage

// File: rtl/flash_read_cache_array.sv
// Tag/valid/data storage for the direct-mapped cache: one write port, combinational read.
module flash_read_cache_array
  import flash_read_cache_pkg::*;
#(
  parameter int unsigned LINES      = 8,
  parameter int unsigned LINE_BYTES = 4,
  parameter int unsigned TAG_W      = 10,
  localparam int unsigned IDX_W     = $clog2(LINES),
  localparam int unsigned OFF_W     = $clog2(LINE_BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [OFF_W-1:0]  rd_offset,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              data_we,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [OFF_W-1:0]  wr_offset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              mark_valid,
  input  logic              inval,
  input  logic [IDX_W-1:0]  inval_index,
  input  logic              clear_all
);
  logic [DATA_W-1:0] data_q [LINES][LINE_BYTES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q;

  assign rd_tag   = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_offset];

  // A flush in the same cycle as a line completion must win over setting valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (inval) begin
      valid_q[inval_index] <= 1'b0;
    end else if (tag_we && mark_valid) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_q[wr_index][wr_offset] <= wr_data;
    if (tag_we)  tag_q[wr_index] <= wr_tag;
  end
endmodule

// File: rtl/flash_read_cache.sv
// Direct-mapped read cache for the SPI flash window; RAM accesses and all writes pass through.
module flash_read_cache
  import flash_read_cache_pkg::*;
#(
  parameter int unsigned LINES      = 8,
  parameter int unsigned LINE_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_address,
  input  logic [DATA_W-1:0] bus_data_tx,
  output logic [DATA_W-1:0] bus_data_rx,
  input  logic              bus_read,
  input  logic              bus_write,
  output logic              bus_wait,
  input  logic              cache_flush,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_tx,
  input  logic [DATA_W-1:0] mem_data_rx,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_wait
);
  localparam int unsigned OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = FLASH_SEL_BIT - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_BYTES - 1);

  state_t            state, next;
  logic [OFF_W-1:0]  cnt;
  logic [TAG_W-1:0]  fill_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic              flush_pend, fill_done;

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              cacheable, line_hit, fresh_hit;
  logic              data_we, tag_we, inval;

  assign tag = bus_address[FLASH_SEL_BIT-1 -: TAG_W];
  assign idx = bus_address[OFF_W +: IDX_W];
  assign off = bus_address[OFF_W-1:0];

  // Read+write together is treated as a write, so it is never cacheable.
  assign cacheable = bus_read && !bus_write && !bus_address[FLASH_SEL_BIT];
  assign line_hit  = rd_valid && (rd_tag == tag);
  // The just-filled line answers once even when a flush left it invalid.
  assign fresh_hit = fill_done && (fill_idx == idx) && (fill_tag == tag);

  flash_read_cache_array #(
    .LINES      (LINES),
    .LINE_BYTES (LINE_BYTES),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_index    (idx),
    .rd_offset   (off),
    .rd_tag      (rd_tag),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .data_we     (data_we),
    .wr_index    (fill_idx),
    .wr_offset   (cnt),
    .wr_data     (mem_data_rx),
    .tag_we      (tag_we),
    .wr_tag      (fill_tag),
    .mark_valid  (!flush_pend),
    .inval       (inval),
    .inval_index (idx),
    .clear_all   (cache_flush)
  );

  always_comb begin
    next        = state;
    bus_wait    = 1'b0;
    bus_data_rx = rd_data;
    mem_address = bus_address;
    mem_data_tx = bus_data_tx;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    inval       = 1'b0;
    case (state)
      IDLE: begin
        if (cacheable) begin
          if (!(line_hit || fresh_hit)) begin
            bus_wait = 1'b1;
            next     = FILL;
          end
        end else if (bus_read || bus_write) begin
          mem_read    = bus_read && !bus_write;
          mem_write   = bus_write;
          bus_wait    = mem_wait;
          bus_data_rx = mem_data_rx;
          inval       = bus_write && !bus_address[FLASH_SEL_BIT] && line_hit && !mem_wait;
        end
      end
      FILL: begin
        bus_wait    = bus_read || bus_write;
        mem_read    = 1'b1;
        mem_address = {{(ADDR_W - FLASH_SEL_BIT){1'b0}}, fill_tag, fill_idx, cnt};
        if (!mem_wait) begin
          data_we = 1'b1;
          if (cnt == LAST) begin
            tag_we = 1'b1;
            next   = IDLE;
          end
        end
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      flush_pend <= 1'b0;
      fill_done  <= 1'b0;
    end else begin
      state     <= next;
      fill_done <= tag_we;
      if (state == IDLE) begin
        cnt        <= '0;
        flush_pend <= 1'b0;
      end else begin
        if (!mem_wait)   cnt        <= cnt + 1'b1;
        if (cache_flush) flush_pend <= 1'b1;
      end
    end
  end

  // Line address is captured while idle so a dropped request cannot disturb a fill.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      fill_tag <= tag;
      fill_idx <= idx;
    end
  end
endmodule

// File: tb/tb_flash_read_cache.sv
// Directed bench for flash_read_cache with a wait-stated memory model and a read-data scoreboard.
module tb_flash_read_cache;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bus_address = '0;
  logic [7:0]  bus_data_tx = '0;
  logic [7:0]  bus_data_rx;
  logic        bus_read = 1'b0;
  logic        bus_write = 1'b0;
  logic        bus_wait;
  logic        cache_flush = 1'b0;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_tx;
  logic [7:0]  mem_data_rx;
  logic        mem_read, mem_write, mem_wait;
  logic        hold_wait = 1'b0;
  logic [1:0]  wcnt = 2'd1;

  int total = 0;
  int bad   = 0;
  logic [15:0] rd_log [$];
  logic [23:0] wr_log [$];
  logic [7:0]  exp_q  [$];
  logic [23:0] wexp_q [$];

  flash_read_cache #(.LINES(8), .LINE_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_address(bus_address), .bus_data_tx(bus_data_tx), .bus_data_rx(bus_data_rx),
    .bus_read(bus_read), .bus_write(bus_write), .bus_wait(bus_wait),
    .cache_flush(cache_flush),
    .mem_address(mem_address), .mem_data_tx(mem_data_tx), .mem_data_rx(mem_data_rx),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wait(mem_wait)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pattern(input logic [15:0] a);
    return a[7:0] ^ {a[14:8], 1'b0} ^ 8'h5A;
  endfunction

  // Memory model: every transfer stalls one cycle, then completes.
  assign mem_data_rx = pattern(mem_address);
  assign mem_wait    = hold_wait || ((mem_read || mem_write) && wcnt != 2'd0);

  always @(posedge clk) begin
    if (mem_read && !mem_wait)  rd_log.push_back(mem_address);
    if (mem_write && !mem_wait) wr_log.push_back({mem_address, mem_data_tx});
    if (!(mem_read || mem_write) || !mem_wait) wcnt <= 2'd1;
    else if (wcnt != 2'd0)                      wcnt <= wcnt - 2'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_rd(input logic [15:0] a, input bit flush2, output int cyc, output int base, output int nrd);
    bit fl_done;
    logic [7:0] e;
    @(negedge clk);
    bus_address = a; bus_read = 1'b1;
    exp_q.push_back(pattern(a));
    base = rd_log.size(); cyc = 0; fl_done = 0;
    #1;
    while (bus_wait && cyc < 200) begin
      if (a[15]) chk("pt_rd_wait", bus_wait, mem_wait);
      @(negedge clk);
      cache_flush = 1'b0;
      if (flush2 && !fl_done && rd_log.size() == base + 1) begin
        cache_flush = 1'b1; fl_done = 1;
      end
      cyc++;
      #1;
    end
    chk("rd_timeout", cyc < 200, 1);
    e = exp_q.pop_front();
    chk("rd_data", bus_data_rx, e);
    @(negedge clk);
    bus_read = 1'b0; cache_flush = 1'b0;
    nrd = rd_log.size() - base;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    int cyc, rbase;
    logic [23:0] e;
    @(negedge clk);
    bus_address = a; bus_data_tx = d; bus_write = 1'b1;
    wexp_q.push_back({a, d});
    rbase = rd_log.size(); cyc = 0;
    #1;
    while (bus_wait && cyc < 200) begin
      chk("pt_wr_wait", bus_wait, mem_wait);
      @(negedge clk); cyc++; #1;
    end
    chk("wr_timeout", cyc < 200, 1);
    @(negedge clk);
    bus_write = 1'b0;
    e = wexp_q.pop_front();
    chk("wr_count", (wr_log.size() > 0) ? 1 : 0, 1);
    if (wr_log.size() > 0) chk("wr_entry", wr_log[wr_log.size()-1], e);
    chk("wr_no_read", rd_log.size() - rbase, 0);
  endtask

  task automatic chk_fill(input int base, input logic [15:0] line);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] got;
      got = (base + i < rd_log.size()) ? rd_log[base + i] : 16'hXXXX;
      chk("fill_addr", got, line + 16'(i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cyc, base, nrd;
    #12;
    chk("rst_bus_wait", bus_wait, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Cold miss then hit on the same line.
    bus_rd(16'h0123, 0, cyc, base, nrd);
    chk("cold_nrd", nrd, 4);
    chk_fill(base, 16'h0120);
    chk("cold_stalled", cyc > 0, 1);
    bus_rd(16'h0121, 0, cyc, base, nrd);
    chk("hit_nowait", cyc, 0);
    chk("hit_nrd", nrd, 0);

    // Conflict on index 0 evicts the previous line.
    bus_rd(16'h0020, 0, cyc, base, nrd);
    chk("conf_nrd", nrd, 4);
    chk_fill(base, 16'h0020);
    bus_rd(16'h0120, 0, cyc, base, nrd);
    chk("evict_nrd", nrd, 4);

    // RAM window passes through and is never cached.
    bus_rd(16'h8005, 0, cyc, base, nrd);
    chk("pt_nrd", nrd, 1);
    chk("pt_addr", rd_log[base], 16'h8005);
    bus_rd(16'h8005, 0, cyc, base, nrd);
    chk("pt_again_nrd", nrd, 1);
    chk("pt_again_stall", cyc > 0, 1);
    bus_wr(16'h8005, 8'hA5);

    // Flush during fill: data still returned, line left invalid.
    bus_rd(16'h0040, 1, cyc, base, nrd);
    chk("flush_nrd", nrd, 4);
    bus_rd(16'h0040, 0, cyc, base, nrd);
    chk("flush_refill_nrd", nrd, 4);
    bus_rd(16'h0040, 0, cyc, base, nrd);
    chk("post_refill_hit", nrd, 0);

    // Write to a valid flash line forwards and invalidates.
    bus_rd(16'h0121, 0, cyc, base, nrd);
    chk("pre_wr_nrd", nrd, 4);
    bus_rd(16'h0122, 0, cyc, base, nrd);
    chk("pre_wr_hit", nrd, 0);
    bus_wr(16'h0121, 8'h3C);
    bus_rd(16'h0121, 0, cyc, base, nrd);
    chk("post_wr_nrd", nrd, 4);
    bus_rd(16'h0123, 0, cyc, base, nrd);
    chk("pre_rst_hit", nrd, 0);

    // Async reset in the middle of a stalled fill.
    @(negedge clk);
    hold_wait = 1'b1; bus_address = 16'h0064; bus_read = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("fill_active", mem_read, 1);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_mem_read", mem_read, 0);
    @(negedge clk); bus_read = 1'b0; hold_wait = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    bus_rd(16'h0123, 0, cyc, base, nrd);
    chk("post_rst_miss", nrd, 4);
    chk_fill(base, 16'h0120);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
